// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - one master's request/response port on the shared RAM arbiter
// The master modport drives the request; the slave modport is the arbiter side.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  req;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wmask;
  logic                  gnt;
  logic [DATA_W-1:0]     rdata;
  logic                  rvalid;

  modport master (
    output req, addr, wdata, wmask,
    input  gnt, rdata, rvalid
  );

  modport slave (
    input  req, addr, wdata, wmask,
    output gnt, rdata, rvalid
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master round-robin arbiter for the single RAM port
// Issues one transaction per cycle and routes read data back through a tag pipeline.
module mem_bus_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  mem_bus_arbiter_if.slave    m0,
  mem_bus_arbiter_if.slave    m1,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  output logic                mem_rstrb,
  input  logic [DATA_W-1:0]   mem_rdata
);

  logic                    last_gnt_q, last_gnt_d;
  logic [READ_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [READ_LATENCY-1:0] tag_own_q, tag_own_d;

  logic                    grant;
  logic                    sel;
  logic                    is_write;
  logic                    rd_issue;
  logic [DATA_W/8-1:0]     sel_wmask;

  // Contended cycles go to whoever was not granted last; reset masks all issue.
  always_comb begin
    grant = (m0.req | m1.req) & ~reset;
    if (m0.req & m1.req) begin
      sel = ~last_gnt_q;
    end else begin
      sel = m1.req;
    end
  end

  always_comb begin
    sel_wmask = sel ? m1.wmask : m0.wmask;
    is_write  = |sel_wmask;
    rd_issue  = grant & ~is_write;
  end

  always_comb begin
    mem_addr  = sel ? m1.addr  : m0.addr;
    mem_wdata = sel ? m1.wdata : m0.wdata;
    mem_wmask = (grant & is_write) ? sel_wmask : '0;
    mem_rstrb = rd_issue;
  end

  always_comb begin
    m0.gnt = grant & ~sel;
    m1.gnt = grant &  sel;
  end

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (grant) begin
      last_gnt_d = sel;
    end
  end

  // Writes push an empty tag so the pipeline stays aligned with memory latency.
  always_comb begin
    tag_vld_d = tag_vld_q;
    tag_own_d = tag_own_q;
    for (int i = READ_LATENCY - 1; i > 0; i--) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_own_d[i] = tag_own_q[i-1];
    end
    tag_vld_d[0] = rd_issue;
    tag_own_d[0] = sel;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_gnt_q <= 1'b1;
      tag_vld_q  <= '0;
      tag_own_q  <= '0;
    end else begin
      last_gnt_q <= last_gnt_d;
      tag_vld_q  <= tag_vld_d;
      tag_own_q  <= tag_own_d;
    end
  end

  always_comb begin
    m0.rdata  = mem_rdata;
    m1.rdata  = mem_rdata;
    m0.rvalid = tag_vld_q[READ_LATENCY-1] & ~tag_own_q[READ_LATENCY-1];
    m1.rvalid = tag_vld_q[READ_LATENCY-1] &  tag_own_q[READ_LATENCY-1];
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed checks for mem_bus_arbiter at read latency 1 and 3
module tb_mem_bus_arbiter;

  logic        clk;
  logic        reset;
  int          errors;
  int          checks;

  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) a0 ();
  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) a1 ();
  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b0 ();
  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();

  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [3:0]  a_wmask;
  logic        a_rstrb;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [3:0]  b_wmask;
  logic        b_rstrb;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(1)) dut_a (
    .clk(clk), .reset(reset), .m0(a0), .m1(a1),
    .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_wmask(a_wmask),
    .mem_rstrb(a_rstrb), .mem_rdata(a_rdata)
  );

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(3)) dut_b (
    .clk(clk), .reset(reset), .m0(b0), .m1(b1),
    .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_wmask(b_wmask),
    .mem_rstrb(b_rstrb), .mem_rdata(b_rdata)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    a0.req = 0; a0.addr = 0; a0.wdata = 0; a0.wmask = 0;
    a1.req = 0; a1.addr = 0; a1.wdata = 0; a1.wmask = 0;
    b0.req = 0; b0.addr = 0; b0.wdata = 0; b0.wmask = 0;
    b1.req = 0; b1.addr = 0; b1.wdata = 0; b1.wmask = 0;
    a_rdata = 0;
    b_rdata = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    a0.req = 1; a0.addr = 32'h4; a0.wmask = 4'h0;
    cyc(); cyc();
    #1;
    checks++;
    if ({a0.gnt, a1.gnt, a_rstrb, a_wmask, a0.rvalid, a1.rvalid} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 0", {a0.gnt, a1.gnt, a_rstrb, a_wmask, a0.rvalid, a1.rvalid});
    end
    reset = 0;
    #1;
    checks++;
    if ({a0.gnt, a1.gnt, a_rstrb} !== 3'b101) begin
      errors++;
      $display("FAIL reset_release_grant: got %b want 101", {a0.gnt, a1.gnt, a_rstrb});
    end
    a0.req = 0;
    cyc(); cyc();
  endtask

  task automatic test_single_read();
    a0.req = 1; a0.addr = 32'h10; a0.wmask = 4'h0;
    #1;
    checks++;
    if ({a0.gnt, a1.gnt, a_rstrb, a_wmask} !== 7'b1010000 || a_addr !== 32'h10) begin
      errors++;
      $display("FAIL single_read_issue: got gnt/rstrb/wmask %b addr %h want 1010000 addr 10", {a0.gnt, a1.gnt, a_rstrb, a_wmask}, a_addr);
    end
    cyc();
    a0.req = 0;
    a_rdata = 32'hDEADBEEF;
    #1;
    checks++;
    if ({a0.rvalid, a1.rvalid} !== 2'b10 || a0.rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_read_return: got rvalid %b data %h want 10 deadbeef", {a0.rvalid, a1.rvalid}, a0.rdata);
    end
    cyc();
    checks++;
    if ({a0.rvalid, a1.rvalid} !== 2'b00) begin
      errors++;
      $display("FAIL single_read_one_pulse: got rvalid %b want 00", {a0.rvalid, a1.rvalid});
    end
  endtask

  task automatic test_idle();
    a0.addr = 32'h44; a0.wdata = 32'h55; a0.wmask = 4'hF;
    a1.addr = 32'h88; a1.wdata = 32'h99;
    #1;
    checks++;
    if (a_addr !== 32'h44 || a_wdata !== 32'h55 || {a_rstrb, a_wmask, a0.gnt, a1.gnt} !== 7'b0) begin
      errors++;
      $display("FAIL idle_bus: got addr %h wdata %h ctl %b want 44 55 0", a_addr, a_wdata, {a_rstrb, a_wmask, a0.gnt, a1.gnt});
    end
    a0.wmask = 4'h0;
    cyc();
  endtask

  task automatic test_contention();
    logic [1:0]  exp_g;
    logic [31:0] exp_addr;
    reset = 1;
    #1;
    reset = 0;
    a0.addr = 32'h0;   a0.wmask = 4'h0; a0.req = 1;
    a1.addr = 32'h100; a1.wmask = 4'h0; a1.req = 1;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) begin
        a0.req = 0;
        a1.req = 0;
      end
      a_rdata = 32'hA000 + k;
      #1;
      if (k < 4) begin
        exp_g    = (k % 2 == 0) ? 2'b10 : 2'b01;
        exp_addr = (k % 2 == 0) ? 32'h0 : 32'h100;
        checks++;
        if ({a0.gnt, a1.gnt} !== exp_g || a_addr !== exp_addr || a_rstrb !== 1'b1) begin
          errors++;
          $display("FAIL contention_grant_%0d: got gnt %b addr %h rstrb %b want %b %h 1", k, {a0.gnt, a1.gnt}, a_addr, a_rstrb, exp_g, exp_addr);
        end
      end
      exp_g = (k == 0) ? 2'b00 : (((k - 1) % 2 == 0) ? 2'b10 : 2'b01);
      checks++;
      if ({a0.rvalid, a1.rvalid} !== exp_g || (k > 0 && a1.rdata !== 32'hA000 + k)) begin
        errors++;
        $display("FAIL contention_rvalid_%0d: got rvalid %b data %h want %b", k, {a0.rvalid, a1.rvalid}, a1.rdata, exp_g);
      end
      cyc();
    end
  endtask

  task automatic test_write_then_read();
    a1.req = 1; a1.addr = 32'h20; a1.wdata = 32'h12345678; a1.wmask = 4'hF;
    #1;
    checks++;
    if ({a0.gnt, a1.gnt, a_rstrb} !== 3'b010 || a_wmask !== 4'hF || a_wdata !== 32'h12345678 || a_addr !== 32'h20) begin
      errors++;
      $display("FAIL wr_issue: got gnt/rstrb %b wmask %h wdata %h addr %h want 010 f 12345678 20", {a0.gnt, a1.gnt, a_rstrb}, a_wmask, a_wdata, a_addr);
    end
    cyc();
    a1.wmask = 4'h0;
    #1;
    checks++;
    if ({a1.gnt, a_rstrb, a_wmask, a0.rvalid, a1.rvalid} !== 8'b11000000) begin
      errors++;
      $display("FAIL rd_after_wr_issue: got %b want 11000000", {a1.gnt, a_rstrb, a_wmask, a0.rvalid, a1.rvalid});
    end
    cyc();
    a1.req = 0;
    a_rdata = 32'h12345678;
    #1;
    checks++;
    if ({a0.rvalid, a1.rvalid} !== 2'b01 || a1.rdata !== 32'h12345678) begin
      errors++;
      $display("FAIL rd_after_wr_return: got rvalid %b data %h want 01 12345678", {a0.rvalid, a1.rvalid}, a1.rdata);
    end
    cyc();
  endtask

  task automatic test_mid_reset();
    a0.req = 1; a0.addr = 32'h30; a0.wmask = 4'h0;
    #1;
    checks++;
    if (a0.gnt !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_grant: got %b want 1", a0.gnt);
    end
    reset = 1;
    #1;
    checks++;
    if ({a0.gnt, a_rstrb, a_wmask} !== 6'b0) begin
      errors++;
      $display("FAIL mid_reset_mask: got %b want 0", {a0.gnt, a_rstrb, a_wmask});
    end
    cyc();
    reset = 0;
    a0.req = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if ({a0.rvalid, a1.rvalid} !== 2'b00) begin
        errors++;
        $display("FAIL mid_reset_drop_%0d: got rvalid %b want 00", k, {a0.rvalid, a1.rvalid});
      end
      cyc();
    end
  endtask

  task automatic test_latency3();
    logic [1:0] exp_g, exp_v;
    b0.addr = 32'h40; b0.wmask = 4'h0;
    b1.addr = 32'h50; b1.wmask = 4'h0;
    for (int k = 0; k < 6; k++) begin
      b0.req = (k == 0);
      b1.req = (k == 1);
      b_rdata = 32'hB000 + k;
      #1;
      exp_g = (k == 0) ? 2'b10 : (k == 1) ? 2'b01 : 2'b00;
      exp_v = (k == 3) ? 2'b10 : (k == 4) ? 2'b01 : 2'b00;
      checks++;
      if ({b0.gnt, b1.gnt} !== exp_g) begin
        errors++;
        $display("FAIL lat3_grant_%0d: got %b want %b", k, {b0.gnt, b1.gnt}, exp_g);
      end
      checks++;
      if ({b0.rvalid, b1.rvalid} !== exp_v || b0.rdata !== 32'hB000 + k) begin
        errors++;
        $display("FAIL lat3_rvalid_%0d: got %b data %h want %b", k, {b0.rvalid, b1.rvalid}, b0.rdata, exp_v);
      end
      cyc();
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    clk = 0;
    reset = 1;
    idle_all();
    test_reset();
    test_single_read();
    test_idle();
    test_contention();
    test_write_then_read();
    test_mid_reset();
    test_latency3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
